// File: rtl/gradient_outlet_sampler.sv
// Sweeps N_OUT gradient outlets: flush each outlet for a dwell time, take one
// detector sample, hand the result off with valid/ready, then advance to the next outlet.
module gradient_outlet_sampler #(
  parameter int N_OUT   = 6,
  parameter int DATA_W  = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   valve_sel,
  output logic               adc_req,
  input  logic               adc_ack,
  input  logic [DATA_W-1:0]  adc_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [2:0]         res_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, FLUSH, SAMPLE, RESULT, NEXT} state_t;

  state_t             state, state_nxt;
  logic [2:0]         idx;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_lat;
  logic               flush_end;
  logic               last_out;

  // A zero dwell behaves as one, so the flush ends on the first cycle either way.
  assign flush_end = (dwell_lat == '0) || (cnt == dwell_lat - DWELL_W'(1));
  assign last_out  = (idx == 3'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valve_sel = '0;
    adc_req   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FLUSH;
      end
      FLUSH: begin
        valve_sel = N_OUT'(1) << idx;
        if (flush_end) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        valve_sel = N_OUT'(1) << idx;
        adc_req   = 1'b1;
        if (adc_ack) state_nxt = RESULT;
      end
      RESULT: begin
        valve_sel = N_OUT'(1) << idx;
        res_valid = 1'b1;
        if (res_ready) state_nxt = NEXT;
      end
      NEXT: begin
        // Valve stays on the current outlet here; idx advances on the exit edge,
        // so the drive moves straight from one outlet to the next.
        valve_sel = N_OUT'(1) << idx;
        if (last_out) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = FLUSH;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      cnt      <= '0;
      res_data <= '0;
      res_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
            cnt <= '0;
          end
        end
        FLUSH: begin
          cnt <= flush_end ? '0 : cnt + DWELL_W'(1);
        end
        SAMPLE: begin
          if (adc_ack) begin
            res_data <= adc_data;
            res_idx  <= idx;
          end
        end
        NEXT: begin
          idx <= last_out ? 3'd0 : idx + 3'd1;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Dwell is a per-sweep configuration value captured only when a sweep begins.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) dwell_lat <= dwell;
  end

endmodule

// File: tb/tb_gradient_outlet_sampler.sv
// Directed bench for gradient_outlet_sampler: full sweeps, zero dwell,
// backpressure, spurious ack/start and reset mid-sweep.
module tb_gradient_outlet_sampler;
  localparam int N_OUT   = 6;
  localparam int DATA_W  = 12;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic [N_OUT-1:0]   valve_sel;
  logic               adc_req;
  logic               adc_ack;
  logic [DATA_W-1:0]  adc_data;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;
  logic [2:0]         res_idx;
  logic               busy;
  logic               done;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;
  logic               prev_req   = 1'b0;
  logic [N_OUT-1:0]   prev_valve = '0;

  always #5 clk = ~clk;

  gradient_outlet_sampler #(.N_OUT(N_OUT), .DATA_W(DATA_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .dwell(dwell), .valve_sel(valve_sel),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Valve drive must be one-hot or zero, and frozen while a conversion is requested.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valve_onehot0", 32'($onehot0(valve_sel)), 32'd1);
      if (adc_req && prev_req) check("valve_hold_req", 32'(valve_sel), 32'(prev_valve));
      if (done) done_cnt++;
    end
    prev_req   <= adc_req;
    prev_valve <= valve_sel;
  end

  task automatic do_sweep(input int dw, input int stall_idx, input int stall_len,
                          input bit spur, input int rst_idx);
    int flush;
    int exp_fl;
    int d0;
    logic [N_OUT-1:0] oh;
    exp_fl = (dw == 0) ? 1 : dw;
    d0     = done_cnt;
    dwell  = DWELL_W'(dw);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dwell = DWELL_W'(7);
    for (int i = 0; i < N_OUT; i++) begin
      oh    = N_OUT'(1) << i;
      flush = 0;
      while (!adc_req && flush < 100) begin
        check("flush_valve", 32'(valve_sel), 32'(oh));
        if (spur && flush == 0) begin
          adc_ack  = 1'b1;
          adc_data = DATA_W'(12'hBAD);
        end
        flush++;
        @(negedge clk);
        adc_ack = 1'b0;
      end
      check("flush_len", 32'(flush), 32'(exp_fl));
      check("sample_valve", 32'(valve_sel), 32'(oh));
      if (spur) begin
        start = 1'b1;
        dwell = DWELL_W'(9);
      end
      @(negedge clk);
      start = 1'b0;
      dwell = DWELL_W'(7);
      check("req_waiting", 32'(adc_req), 32'd1);
      adc_ack  = 1'b1;
      adc_data = DATA_W'(32'h100 + i);
      @(negedge clk);
      adc_ack  = 1'b0;
      adc_data = '0;
      check("req_dropped", 32'(adc_req), 32'd0);
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_data", 32'(res_data), 32'h100 + i);
      check("res_idx", 32'(res_idx), 32'(i));
      check("result_valve", 32'(valve_sel), 32'(oh));
      if (i == rst_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valve", 32'(valve_sel), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_adc_req", 32'(adc_req), 32'd0);
        check("rst_res_idx", 32'(res_idx), 32'd0);
        return;
      end
      if (i == stall_idx) begin
        res_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          check("stall_valid", 32'(res_valid), 32'd1);
          check("stall_data", 32'(res_data), 32'h100 + i);
          check("stall_idx", 32'(res_idx), 32'(i));
          check("stall_valve", 32'(valve_sel), 32'(oh));
          check("stall_no_req", 32'(adc_req), 32'd0);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
      check("next_done", 32'(done), (i == N_OUT - 1) ? 32'd1 : 32'd0);
      check("next_valve", 32'(valve_sel), 32'(oh));
      check("next_valid_low", 32'(res_valid), 32'd0);
      if (i == N_OUT - 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_valve", 32'(valve_sel), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    dwell     = DWELL_W'(5);
    adc_ack   = 1'b1;
    adc_data  = DATA_W'(12'h3C3);
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valve", 32'(valve_sel), 32'd0);
    check("reset_adc_req", 32'(adc_req), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_data", 32'(res_data), 32'd0);
    check("reset_res_idx", 32'(res_idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst     = 1'b0;
    start   = 1'b0;
    adc_ack = 1'b0;
    mon_en  = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);

    do_sweep(3, 7, 0, 1'b0, 7);   // full sweep
    do_sweep(0, 7, 0, 1'b0, 7);   // zero dwell
    do_sweep(3, 2, 10, 1'b0, 7);  // backpressure on outlet 2
    do_sweep(3, 7, 0, 1'b1, 7);   // spurious ack in FLUSH, start in SAMPLE
    do_sweep(3, 7, 0, 1'b0, 4);   // reset on outlet 4 in RESULT
    do_sweep(2, 7, 0, 1'b0, 7);   // restart after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
